// File: rtl/xgmii_loopback_ctrl_if.sv
// XGMII loopback bus interface: TX word from the MAC, looped RX word back to it.
// master = MAC side (drives TX, receives RX); slave = loopback block.
interface xgmii_loopback_ctrl_if #(
  parameter int LANES = 8
);
  logic [8*LANES-1:0] xgmii_txd;
  logic [LANES-1:0]   xgmii_txc;
  logic [8*LANES-1:0] xgmii_rxd;
  logic [LANES-1:0]   xgmii_rxc;

  modport master (output xgmii_txd, xgmii_txc, input  xgmii_rxd, xgmii_rxc);
  modport slave  (input  xgmii_txd, xgmii_txc, output xgmii_rxd, xgmii_rxc);
endinterface

// File: rtl/xgmii_loopback_ctrl.sv
// XGMII loopback controller: delays the TX word stream by DELAY clocks into RX,
// tracks frames (start/terminate) and applies a per-frame mode:
// pass, force idle, force local fault, or periodic frame drop.
// Keeps saturating pass/drop frame counters.
// Optional feature macro: XGMII_LB_ERRINJ_EN (one-shot error injection into
// the first data word of the next frame after an err_inj_req pulse).
module xgmii_loopback_ctrl #(
  parameter int LANES = 8,
  parameter int DELAY = 4
) (
  input  logic                 clk_xgmii_tx,
  input  logic                 reset_xgmii_tx_n,
  xgmii_loopback_ctrl_if.slave xgmii,
  input  logic [1:0]           lb_mode,
  input  logic [7:0]           drop_interval,
  input  logic                 err_inj_req,
  output logic [1:0]           mode_active,
  output logic [15:0]          frames_passed,
  output logic [15:0]          frames_dropped
);

  localparam int W = 8 * LANES;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_IDLE   = 2'd1,
    MODE_LFAULT = 2'd2,
    MODE_DROP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  localparam logic [W-1:0]     IDLE_D   = {LANES{8'h07}};
  localparam logic [LANES-1:0] IDLE_C   = {LANES{1'b1}};
  localparam logic [W-1:0]     LFAULT_D = {(LANES / 4){32'h0100_009C}};
  localparam logic [LANES-1:0] LFAULT_C = {(LANES / 4){4'b0001}};

  mode_e          r_mode;
  state_e         r_state;
  logic [7:0]     r_drop_cnt;
  logic [15:0]    r_frames_passed;
  logic [15:0]    r_frames_dropped;
  logic [W-1:0]     r_pipe_d [DELAY];
  logic [LANES-1:0] r_pipe_c [DELAY];

  logic           w_is_start;
  logic           w_is_term;
  logic           w_close;
  logic [7:0]     w_cnt_inc;
  logic           w_drop_new;
  logic [W-1:0]     w_sub_d;
  logic [LANES-1:0] w_sub_c;

  // Frame delimiter detection on the incoming TX word.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    w_is_start = xgmii.xgmii_txc[0] && (xgmii.xgmii_txd[7:0] == 8'hFB);
    w_is_term  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (xgmii.xgmii_txc[i] && (xgmii.xgmii_txd[8*i +: 8] == 8'hFD)) begin
        w_is_term = 1'b1;
      end
    end
  end

  // A start opens a dropped frame when the incremented count hits the interval.
  assign w_cnt_inc  = r_drop_cnt + 8'd1;
  assign w_drop_new = w_is_start && (r_mode == MODE_DROP) &&
                      (drop_interval != 8'd0) && (w_cnt_inc == drop_interval);
  // A frame closes on its terminate or on a new start that preempts it.
  assign w_close    = (r_state != S_IDLE) && (w_is_start || w_is_term);

`ifdef XGMII_LB_ERRINJ_EN
  logic r_err_armed;
  logic w_inj_fire;

  // Inject only into a mid-frame data word that actually reaches the output.
  assign w_inj_fire = r_err_armed && (r_state == S_FRAME) && !w_is_start && !w_is_term &&
                      ((r_mode == MODE_PASS) || (r_mode == MODE_DROP));

  // One-shot arm flag: set by a request, cleared when the error is injected.
  always_ff @(posedge clk_xgmii_tx) begin
    if (!reset_xgmii_tx_n) begin
      r_err_armed <= 1'b0;
    end else if (w_inj_fire) begin
      r_err_armed <= 1'b0;
    end else if (err_inj_req) begin
      r_err_armed <= 1'b1;
    end
  end
`else
  logic w_unused_err_inj;
  assign w_unused_err_inj = err_inj_req;
`endif

  // Word substitution for the word entering pipeline stage 0.
  always_comb begin
    w_sub_d = xgmii.xgmii_txd;
    w_sub_c = xgmii.xgmii_txc;
`ifdef XGMII_LB_ERRINJ_EN
    if (w_inj_fire) begin
      w_sub_d[15:8] = 8'hFE;
      w_sub_c[1]    = 1'b1;
    end
`endif
    case (r_mode)
      MODE_IDLE: begin
        w_sub_d = IDLE_D;
        w_sub_c = IDLE_C;
      end
      MODE_LFAULT: begin
        w_sub_d = LFAULT_D;
        w_sub_c = LFAULT_C;
      end
      MODE_DROP: begin
        // The start word of a new frame follows the new decision; others follow the state.
        if (w_is_start ? w_drop_new : (r_state == S_DROP)) begin
          w_sub_d = IDLE_D;
          w_sub_c = IDLE_C;
        end
      end
      default: ;
    endcase
  end

  // Frame parser, mode latch, drop counter and saturating frame counters.
  always_ff @(posedge clk_xgmii_tx) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_xgmii_tx_n) begin
      r_mode           <= MODE_PASS;
      r_state          <= S_IDLE;
      r_drop_cnt       <= 8'd0;
      r_frames_passed  <= 16'd0;
      r_frames_dropped <= 16'd0;
    end else begin
      // Mode changes only take effect in an inter-frame gap.
      if ((r_state == S_IDLE) && !w_is_start) begin
        r_mode <= mode_e'(lb_mode);
      end

      if (w_is_start) begin
        r_state <= w_drop_new ? S_DROP : S_FRAME;
        if (r_mode == MODE_DROP) begin
          if (drop_interval == 8'd0) begin
            r_drop_cnt <= 8'd0;
          end else begin
            r_drop_cnt <= w_drop_new ? 8'd0 : w_cnt_inc;
          end
        end
      end else if (w_is_term && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end

      if (w_close) begin
        if ((r_state == S_FRAME) && ((r_mode == MODE_PASS) || (r_mode == MODE_DROP)) &&
            (r_frames_passed != 16'hFFFF)) begin
          r_frames_passed <= r_frames_passed + 16'd1;
        end
        if ((r_state == S_DROP) && (r_frames_dropped != 16'hFFFF)) begin
          r_frames_dropped <= r_frames_dropped + 16'd1;
        end
      end
    end
  end

  // Fixed-depth delay line; RX sees the substituted word exactly DELAY clocks later.
  always_ff @(posedge clk_xgmii_tx) begin
    // NOTE: the delay line is reset (to IDLE) because RX must see valid idles right after reset.
    if (!reset_xgmii_tx_n) begin
      for (int i = 0; i < DELAY; i++) begin
        r_pipe_d[i] <= IDLE_D;
        r_pipe_c[i] <= IDLE_C;
      end
    end else begin
      r_pipe_d[0] <= w_sub_d;
      r_pipe_c[0] <= w_sub_c;
      for (int i = 1; i < DELAY; i++) begin
        r_pipe_d[i] <= r_pipe_d[i-1];
        r_pipe_c[i] <= r_pipe_c[i-1];
      end
    end
  end

  assign xgmii.xgmii_rxd = r_pipe_d[DELAY-1];
  assign xgmii.xgmii_rxc = r_pipe_c[DELAY-1];
  assign mode_active     = r_mode;
  assign frames_passed   = r_frames_passed;
  assign frames_dropped  = r_frames_dropped;

endmodule

// File: tb/tb_xgmii_loopback_ctrl.sv
// Self-checking bench for xgmii_loopback_ctrl (LANES=8, DELAY=4).
// Expected RX words are pushed to a scoreboard queue as each TX word is driven
// and popped/compared as the DUT emits them. Define XGMII_LB_ERRINJ_EN to
// exercise error injection.
`timescale 1ns/1ps
module tb_xgmii_loopback_ctrl;

  localparam int LANES = 8;
  localparam int DELAY = 4;
  localparam int W     = 8 * LANES;

  localparam logic [W-1:0]     IDLE_D = 64'h0707070707070707;
  localparam logic [LANES-1:0] IDLE_C = 8'hFF;
  localparam logic [W-1:0]     LF_D   = 64'h0100009C_0100009C;
  localparam logic [LANES-1:0] LF_C   = 8'h11;

  typedef enum int {K_SAME, K_IDLE, K_LF, K_INJ} kind_e;

  typedef struct {
    logic [W-1:0]     d;
    logic [LANES-1:0] c;
  } word_t;

  typedef struct {
    logic [1:0]       mode;
    logic [W-1:0]     d;
    logic [LANES-1:0] c;
    kind_e            kind;
    logic [1:0]       exp_mode;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  lb_mode = 2'd0;
  logic [7:0]  drop_interval = 8'd0;
  logic        err_inj_req = 1'b0;
  logic [1:0]  mode_active;
  logic [15:0] frames_passed;
  logic [15:0] frames_dropped;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_test = "init";
  word_t sb_q[$];
  vec_t  tbl[8];

  xgmii_loopback_ctrl_if #(.LANES(LANES)) xif ();

  xgmii_loopback_ctrl #(.LANES(LANES), .DELAY(DELAY)) dut (
    .clk_xgmii_tx     (clk),
    .reset_xgmii_tx_n (rst_n),
    .xgmii            (xif),
    .lb_mode          (lb_mode),
    .drop_interval    (drop_interval),
    .err_inj_req      (err_inj_req),
    .mode_active      (mode_active),
    .frames_passed    (frames_passed),
    .frames_dropped   (frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", cur_test, name, act, exp);
    end
  endtask

  // Called at a negedge: compare the emitted word, drive the next word, push its expectation.
  task automatic send(input logic [W-1:0] d, input logic [LANES-1:0] c, input kind_e k);
    word_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.sb_underflow: got empty queue expected an entry", cur_test);
    end else begin
      e = sb_q.pop_front();
      check("rxd", xif.xgmii_rxd, e.d);
      check("rxc", {56'd0, xif.xgmii_rxc}, {56'd0, e.c});
    end
    xif.xgmii_txd = d;
    xif.xgmii_txc = c;
    case (k)
      K_IDLE:  begin e.d = IDLE_D; e.c = IDLE_C; end
      K_LF:    begin e.d = LF_D;   e.c = LF_C;   end
      K_INJ:   begin e.d = d; e.d[15:8] = 8'hFE; e.c = c; e.c[1] = 1'b1; end
      default: begin e.d = d; e.c = c; end
    endcase
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  function automatic word_t frame_word(input int idx, input int n, input int term_lane);
    word_t w;
    w.d = {$urandom, $urandom};
    w.c = '0;
    if (idx == 0) begin
      w.d = 64'hD5555555555555FB;
      w.c = 8'h01;
    end else if (idx == n - 1) begin
      for (int i = 0; i < LANES; i++) begin
        if (i == term_lane) begin
          w.d[8*i +: 8] = 8'hFD;
          w.c[i] = 1'b1;
        end else if (i > term_lane) begin
          w.d[8*i +: 8] = 8'h07;
          w.c[i] = 1'b1;
        end
      end
    end
    return w;
  endfunction

  task automatic send_frame(input int n, input int term_lane, input kind_e k);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w = frame_word(i, n, term_lane);
      send(w.d, w.c, k);
    end
  endtask

  task automatic send_gap(input int n, input kind_e k);
    for (int i = 0; i < n; i++) send(IDLE_D, IDLE_C, k);
  endtask

  // Called at a negedge; returns at a negedge with reset released and the scoreboard primed.
  task automatic do_reset();
    rst_n = 1'b0;
    xif.xgmii_txd = IDLE_D;
    xif.xgmii_txc = IDLE_C;
    err_inj_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mode", {62'd0, mode_active}, 64'd0);
    check("rst_passed", {48'd0, frames_passed}, 64'd0);
    check("rst_dropped", {48'd0, frames_dropped}, 64'd0);
    check("rst_rxd", xif.xgmii_rxd, IDLE_D);
    check("rst_rxc", {56'd0, xif.xgmii_rxc}, {56'd0, IDLE_C});
    rst_n = 1'b1;
    sb_q.delete();
    for (int i = 0; i < DELAY; i++) sb_q.push_back('{IDLE_D, IDLE_C});
  endtask

  initial begin
    word_t w;

    // Gap-word vectors across mode changes; a new mode applies one word after it is requested.
    tbl[0] = '{2'd1, 64'h1122334455667788, 8'h00, K_SAME, 2'd1};
    tbl[1] = '{2'd1, 64'h99AABBCCDDEEFF00, 8'h00, K_IDLE, 2'd1};
    tbl[2] = '{2'd2, 64'h0123456789ABCDEF, 8'h00, K_IDLE, 2'd2};
    tbl[3] = '{2'd2, 64'hFEDCBA9876543210, 8'h00, K_LF,   2'd2};
    tbl[4] = '{2'd3, IDLE_D,               IDLE_C, K_LF,  2'd3};
    tbl[5] = '{2'd3, 64'h1122334455667788, 8'h00, K_SAME, 2'd3};
    tbl[6] = '{2'd0, IDLE_D,               IDLE_C, K_SAME, 2'd0};
    tbl[7] = '{2'd0, 64'hA5A55A5A0F0FF0F0, 8'h80, K_SAME, 2'd0};

    xif.xgmii_txd = IDLE_D;
    xif.xgmii_txc = IDLE_C;
    @(negedge clk);

    // T1: single start word appears exactly DELAY clocks later.
    cur_test = "t1";
    do_reset();
    send(64'h00000000000000FB, 8'h01, K_SAME);
    send_gap(3, K_SAME);
    send(64'h07070707070707FD, 8'hFF, K_SAME);
    check("passed", {48'd0, frames_passed}, 64'd1);

    // Table: gap words under each mode.
    cur_test = "tbl";
    for (int i = 0; i < 8; i++) begin
      lb_mode = tbl[i].mode;
      send(tbl[i].d, tbl[i].c, tbl[i].kind);
      check($sformatf("mode%0d", i), {62'd0, mode_active}, {62'd0, tbl[i].exp_mode});
    end
    send_gap(DELAY, K_SAME);

    // T2: PASS, three frames, then a start that preempts an open frame.
    cur_test = "t2";
    lb_mode = 2'd0;
    do_reset();
    send_gap(2, K_SAME);
    for (int f = 0; f < 3; f++) begin
      send_frame(8, (f == 0) ? 0 : (f == 1) ? 4 : 7, K_SAME);
      send_gap(2, K_SAME);
    end
    check("passed", {48'd0, frames_passed}, 64'd3);
    check("dropped", {48'd0, frames_dropped}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      w = frame_word(i, 5, 0);
      send(w.d, w.c, K_SAME);
    end
    send_frame(4, 2, K_SAME);
    check("passed_b2b", {48'd0, frames_passed}, 64'd5);
    send_gap(DELAY, K_SAME);

    // T3: DROP every 2nd frame, then interval 0 (never) and 1 (always).
    cur_test = "t3";
    lb_mode = 2'd3;
    drop_interval = 8'd2;
    do_reset();
    send_gap(2, K_SAME);
    for (int f = 1; f <= 6; f++) begin
      send_frame(6, f, (f % 2 == 0) ? K_IDLE : K_SAME);
      send_gap(2, K_SAME);
    end
    check("passed", {48'd0, frames_passed}, 64'd3);
    check("dropped", {48'd0, frames_dropped}, 64'd3);
    check("mode", {62'd0, mode_active}, 64'd3);
    drop_interval = 8'd0;
    for (int f = 0; f < 2; f++) begin
      send_frame(5, 3, K_SAME);
      send_gap(2, K_SAME);
    end
    check("passed_int0", {48'd0, frames_passed}, 64'd5);
    drop_interval = 8'd1;
    send_frame(5, 6, K_IDLE);
    send_gap(2, K_SAME);
    check("dropped_int1", {48'd0, frames_dropped}, 64'd4);
    send_gap(DELAY, K_SAME);

    // T4: mode change mid-frame is deferred to the gap.
    cur_test = "t4";
    lb_mode = 2'd0;
    drop_interval = 8'd0;
    do_reset();
    send_gap(2, K_SAME);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) lb_mode = 2'd2;
      w = frame_word(i, 10, 5);
      send(w.d, w.c, K_SAME);
      if (i == 5) check("mode_mid", {62'd0, mode_active}, 64'd0);
    end
    check("mode_term", {62'd0, mode_active}, 64'd0);
    check("passed", {48'd0, frames_passed}, 64'd1);
    send(IDLE_D, IDLE_C, K_SAME);
    check("mode_gap", {62'd0, mode_active}, 64'd2);
    send_gap(3, K_LF);
    send_frame(6, 1, K_LF);
    send_gap(2, K_LF);
    check("passed_lf", {48'd0, frames_passed}, 64'd1);
    send_gap(DELAY, K_LF);

    // T5: frames_passed saturates at 16'hFFFF.
    cur_test = "t5";
    lb_mode = 2'd0;
    do_reset();
    send_gap(2, K_SAME);
    force dut.r_frames_passed = 16'hFFFE;
    send_gap(1, K_SAME);
    release dut.r_frames_passed;
    send_gap(1, K_SAME);
    check("preload", {48'd0, frames_passed}, 64'hFFFE);
    for (int f = 0; f < 3; f++) begin
      send_frame(4, 2, K_SAME);
      send_gap(2, K_SAME);
    end
    check("sat", {48'd0, frames_passed}, 64'hFFFF);
    check("dropped", {48'd0, frames_dropped}, 64'd0);
    send_gap(DELAY, K_SAME);

    // T6: error injection request in the gap.
    cur_test = "t6";
    lb_mode = 2'd0;
    do_reset();
    send_gap(2, K_SAME);
    err_inj_req = 1'b1;
    send(IDLE_D, IDLE_C, K_SAME);
    err_inj_req = 1'b0;
    send_gap(1, K_SAME);
    for (int i = 0; i < 8; i++) begin
      w = frame_word(i, 8, 4);
`ifdef XGMII_LB_ERRINJ_EN
      send(w.d, w.c, (i == 1) ? K_INJ : K_SAME);
`else
      send(w.d, w.c, K_SAME);
`endif
    end
    send_gap(2, K_SAME);
    send_frame(8, 4, K_SAME);
    send_gap(2, K_SAME);
    check("passed", {48'd0, frames_passed}, 64'd2);
    send_gap(DELAY, K_SAME);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
